// File: rtl/cla8_pkg.sv
// Shared types and helpers for the CLA operand-launch / result-capture stage.
package cla8_pkg;

  localparam int unsigned CLA_WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Two's-complement overflow: operands agree in sign, result sign differs.
  function automatic logic ovf_from_msbs(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/cla8_settle_counter.sv
// 4-bit load/decrement counter timing the CLA settle window.
module cla8_settle_counter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_load,
  input  logic [3:0] i_load_val,
  input  logic       i_dec,
  output logic       o_zero
);

  logic [3:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 4'd1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/cla8_io_stage.sv
// Registers operands onto an external CLA, waits for it to settle, captures
// sum/carry/overflow and cross-checks the result against a behavioural add.
module cla8_io_stage
  import cla8_pkg::*;
#(
  parameter int unsigned WIDTH         = CLA_WIDTH,
  parameter int unsigned SETTLE_CYCLES = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] cla_a,
  output logic [WIDTH-1:0] cla_b,
  output logic             cla_cin,
  input  logic [WIDTH-1:0] cla_sum,
  input  logic             cla_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             chk_err
);

  localparam logic [3:0] LOAD_VAL = 4'(SETTLE_CYCLES - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_cla_a;
  logic [WIDTH-1:0] r_cla_b;
  logic             r_cla_cin;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_err;

  logic             w_accept;
  logic             w_zero;
  logic [WIDTH:0]   w_ref;

  assign w_accept = (r_state == IDLE) && in_valid;
  assign w_ref    = {1'b0, r_cla_a} + {1'b0, r_cla_b} + {{WIDTH{1'b0}}, r_cla_cin};

  cla8_settle_counter u_settle (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (w_accept),
    .i_load_val (LOAD_VAL),
    .i_dec      (r_state == SETTLE),
    .o_zero     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_cla_a   <= '0;
      r_cla_b   <= '0;
      r_cla_cin <= 1'b0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_ovf     <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_cla_a   <= a;
            r_cla_b   <= b;
            r_cla_cin <= cin;
            r_state   <= SETTLE;
          end
        end
        SETTLE: begin
          if (w_zero) begin
            r_sum   <= cla_sum;
            r_cout  <= cla_cout;
            r_ovf   <= ovf_from_msbs(r_cla_a[WIDTH-1], r_cla_b[WIDTH-1], cla_sum[WIDTH-1]);
            if (w_ref != {cla_cout, cla_sum}) r_err <= 1'b1;
            r_state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign cla_a     = r_cla_a;
  assign cla_b     = r_cla_b;
  assign cla_cin   = r_cla_cin;
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign overflow  = r_ovf;
  assign chk_err   = r_err;

endmodule

// File: tb/tb_cla8_io_stage.sv
// Scoreboard bench for cla8_io_stage with a behavioural CLA in the parent role.
module tb_cla8_io_stage;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [7:0] cla_a, cla_b;
  logic       cla_cin;
  logic [7:0] cla_sum;
  logic       cla_cout;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout, overflow, chk_err;

  logic       corrupt = 1'b0;
  logic [8:0] w_model;

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       e;
  } exp_t;

  exp_t        q[$];
  int          total = 0;
  int          bad = 0;
  int unsigned cyc = 0;
  int unsigned acc_cyc = 0;
  logic        ov_prev = 1'b0;

  cla8_io_stage #(.WIDTH(8), .SETTLE_CYCLES(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
    .cla_a(cla_a), .cla_b(cla_b), .cla_cin(cla_cin),
    .cla_sum(cla_sum), .cla_cout(cla_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .overflow(overflow), .chk_err(chk_err)
  );

  // Stand-in for the external CLA; corrupt forces a wrong sum for the checker test.
  assign w_model  = {1'b0, cla_a} + {1'b0, cla_b} + {8'd0, cla_cin};
  assign cla_sum  = corrupt ? 8'h00 : w_model[7:0];
  assign cla_cout = corrupt ? 1'b0 : w_model[8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per output handshake.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && !ov_prev) chk("latency", cyc - acc_cyc, 3);
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_result", {31'd0, out_valid}, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("sum", {24'd0, sum}, {24'd0, e.s});
          chk("cout", {31'd0, cout}, {31'd0, e.c});
          chk("overflow", {31'd0, overflow}, {31'd0, e.o});
          chk("chk_err", {31'd0, chk_err}, {31'd0, e.e});
        end
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                      input logic [7:0] es, input logic ec, input logic eo, input logic ee,
                      input bit push);
    int unsigned n = 0;
    exp_t e;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", {31'd0, in_ready}, 1);
      return;
    end
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    e.s = es; e.c = ec; e.o = eo; e.e = ee;
    if (push) q.push_back(e);
    @(posedge clk);
    acc_cyc = cyc + 1;
    #1;
    in_valid = 1'b0;
    chk("cla_a", {24'd0, cla_a}, {24'd0, ta});
    chk("cla_b", {24'd0, cla_b}, {24'd0, tb});
    chk("cla_cin", {31'd0, cla_cin}, {31'd0, tc});
  endtask

  task automatic drain();
    int unsigned n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
  endtask

  initial begin
    int unsigned t_prev;
    logic [7:0]  s_hold;
    logic        c_hold, o_hold;
    int unsigned n;

    #23 rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 1);
    chk("rst_out_valid", {31'd0, out_valid}, 0);
    chk("rst_sum", {24'd0, sum}, 0);
    chk("rst_cout", {31'd0, cout}, 0);
    chk("rst_overflow", {31'd0, overflow}, 0);
    chk("rst_chk_err", {31'd0, chk_err}, 0);
    chk("rst_cla_a", {24'd0, cla_a}, 0);

    send(8'h3C, 8'h45, 1'b0, 8'h81, 1'b0, 1'b1, 1'b0, 1'b1);
    drain();

    // Carry chain then back-to-back with out_ready held high.
    send(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    t_prev = acc_cyc;
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("spacing1", acc_cyc - t_prev, 5);
    t_prev = acc_cyc;
    send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("spacing2", acc_cyc - t_prev, 5);
    t_prev = acc_cyc;
    send(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("spacing3", acc_cyc - t_prev, 5);
    drain();

    // Backpressure: result held, new operands ignored.
    out_ready = 1'b0;
    send(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp_out_valid_rise", {31'd0, out_valid}, 1);
    s_hold = sum; c_hold = cout; o_hold = overflow;
    for (int i = 0; i < 10; i++) begin
      a = 8'hA5 ^ 8'(i); b = 8'h5A + 8'(i); in_valid = 1'b1;
      @(negedge clk);
      chk("bp_sum", {24'd0, sum}, {24'd0, s_hold});
      chk("bp_cout", {30'd0, cout, overflow}, {30'd0, c_hold, o_hold});
      chk("bp_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
      chk("bp_cla_a", {24'd0, cla_a}, 32'h10);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("bp_release_in_ready", {31'd0, in_ready}, 1);
    drain();

    // Checker: corrupted CLA output sets a sticky error.
    corrupt = 1'b1;
    send(8'h01, 8'h01, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    corrupt = 1'b0;
    send(8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0, 1'b1, 1'b1);
    drain();
    chk("err_sticky", {31'd0, chk_err}, 1);

    // Reset during SETTLE discards the pending request.
    send(8'h22, 8'h33, 1'b0, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", {31'd0, in_ready}, 1);
    chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
    chk("mid_rst_cla_a", {24'd0, cla_a}, 0);
    chk("mid_rst_sum", {24'd0, sum}, 0);
    chk("mid_rst_flags", {29'd0, cout, overflow, chk_err}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (out_valid) n++;
    end
    chk("mid_rst_no_result", n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
